// File: rtl/scroll_pkg.sv
// -----------------------------------------------------------------------------
// scroll_pkg
// Shared definitions for the scrolling 7-segment display engine:
//   - default parameter values for scroll_display_ctrl
//   - character code constants for the letters the font supports
//   - seg_font(): character code -> active-high segments {dp,g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
package scroll_pkg;

  localparam int DEF_N_DIGITS = 8;
  localparam int DEF_MSG_LEN  = 16;
  localparam int DEF_CHAR_W   = 5;
  localparam int DEF_CLK_HZ   = 100_000_000;
  localparam int DEF_SCAN_HZ  = 1000;
  localparam int DEF_STEP_HZ  = 4;

  // Codes 0..9 are the decimal digits themselves.
  localparam int CH_H     = 10;
  localparam int CH_E     = 11;
  localparam int CH_U     = 12;
  localparam int CH_L     = 13;
  localparam int CH_J     = 14;
  localparam int CH_Y     = 15;
  localparam int CH_A     = 16;
  localparam int CH_C     = 17;
  localparam int CH_P     = 18;
  localparam int CH_BLANK = 31;

  // Any code without a glyph renders as blank.
  function automatic logic [7:0] seg_font(input int unsigned code);
    case (code)
      0:       seg_font = 8'h3F;
      1:       seg_font = 8'h06;
      2:       seg_font = 8'h5B;
      3:       seg_font = 8'h4F;
      4:       seg_font = 8'h66;
      5:       seg_font = 8'h6D;
      6:       seg_font = 8'h7D;
      7:       seg_font = 8'h07;
      8:       seg_font = 8'h7F;
      9:       seg_font = 8'h6F;
      CH_H:    seg_font = 8'h76;
      CH_E:    seg_font = 8'h79;
      CH_U:    seg_font = 8'h3E;
      CH_L:    seg_font = 8'h38;
      CH_J:    seg_font = 8'h1E;
      CH_Y:    seg_font = 8'h6E;
      CH_A:    seg_font = 8'h77;
      CH_C:    seg_font = 8'h39;
      CH_P:    seg_font = 8'h73;
      default: seg_font = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/scroll_display_ctrl_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Free-running divider producing a one-cycle clock enable every DIV cycles.
//   clk  : system clock
//   rst  : synchronous active-high reset (counter to 0)
//   tick : high for one cycle while the counter sits at DIV-1
// With DIV = 1 the tick is permanently high.
// -----------------------------------------------------------------------------
module tick_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] count;

  assign tick = (count == CW'(DIV - 1));

  // Count up to DIV-1, then wrap to 0 on the tick cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/scroll_display_ctrl.sv
// -----------------------------------------------------------------------------
// scroll_display_ctrl
// Scrolling-text engine for a two-bank multiplexed 7-segment display.
// A shadow message buffer is written by user logic and copied to the active
// buffer on request at the next scroll step; the active buffer is rotated
// left or right across the digits and scanned one digit per bank at a time.
//   clk, rst      : clock, synchronous active-high reset
//   pause         : freezes the scroll offset (swaps still execute)
//   dir           : 0 = scroll left (offset+1), 1 = scroll right (offset-1)
//   wr_en/addr/data : write one character into the shadow buffer
//   swap          : pulse, request shadow->active copy at the next step
//   swap_pending  : swap requested but not yet executed
//   offset        : current scroll offset
//   an            : anode enables, an[N_DIGITS-1] is the leftmost digit
//   duan / duan1  : segments of the right / left bank digit being scanned
// -----------------------------------------------------------------------------
module scroll_display_ctrl
  import scroll_pkg::*;
#(
  parameter int N_DIGITS = DEF_N_DIGITS,
  parameter int MSG_LEN  = DEF_MSG_LEN,
  parameter int CHAR_W   = DEF_CHAR_W,
  parameter int CLK_HZ   = DEF_CLK_HZ,
  parameter int SCAN_HZ  = DEF_SCAN_HZ,
  parameter int STEP_HZ  = DEF_STEP_HZ
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pause,
  input  logic                       dir,
  input  logic                       wr_en,
  input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
  input  logic [CHAR_W-1:0]          wr_data,
  input  logic                       swap,
  output logic                       swap_pending,
  output logic [$clog2(MSG_LEN)-1:0] offset,
  output logic [N_DIGITS-1:0]        an,
  output logic [7:0]                 duan,
  output logic [7:0]                 duan1
);

  localparam int AW       = $clog2(MSG_LEN);
  localparam int HALF     = N_DIGITS / 2;
  localparam int KW       = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int SCAN_RAW = CLK_HZ / SCAN_HZ;
  localparam int STEP_RAW = CLK_HZ / STEP_HZ;
  localparam int SCAN_DIV = (SCAN_RAW < 1) ? 1 : SCAN_RAW;
  localparam int STEP_DIV = (STEP_RAW < 1) ? 1 : STEP_RAW;

  logic              scan_tick;
  logic              step_tick;
  logic              swap_exec;
  logic              addr_ok;
  logic [CHAR_W-1:0] shadow [MSG_LEN];
  logic [CHAR_W-1:0] active [MSG_LEN];
  logic [KW-1:0]     scan_idx;
  logic [AW-1:0]     idx_right;
  logic [AW-1:0]     idx_left;
  logic [N_DIGITS-1:0] an_low;

  tick_gen #(.DIV(SCAN_DIV)) u_scan_tick (.clk(clk), .rst(rst), .tick(scan_tick));
  tick_gen #(.DIV(STEP_DIV)) u_step_tick (.clk(clk), .rst(rst), .tick(step_tick));

  // A request made in the tick cycle itself executes immediately.
  assign swap_exec = step_tick && (swap_pending || swap);

  // Only a non power-of-two message length can see out-of-range addresses.
  if ((1 << AW) > MSG_LEN) begin : g_addr_check
    assign addr_ok = (wr_addr < AW'(MSG_LEN));
  end else begin : g_addr_all
    assign addr_ok = 1'b1;
  end

  // Shadow buffer: the only buffer user logic can write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MSG_LEN; i++) shadow[i] <= CHAR_W'(CH_BLANK);
    end else if (wr_en && addr_ok) begin
      shadow[wr_addr] <= wr_data;
    end
  end

  // Active buffer copies the pre-edge shadow, so a same-cycle write is not
  // part of the copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MSG_LEN; i++) active[i] <= CHAR_W'(CH_BLANK);
    end else if (swap_exec) begin
      for (int i = 0; i < MSG_LEN; i++) active[i] <= shadow[i];
    end
  end

  // Swap request tracking and scroll offset; a swap overrides scrolling and
  // is not held off by pause.
  always_ff @(posedge clk) begin
    if (rst) begin
      swap_pending <= 1'b0;
      offset       <= '0;
    end else if (step_tick) begin
      swap_pending <= 1'b0;
      if (swap_exec) begin
        offset <= '0;
      end else if (!pause) begin
        if (dir) begin
          offset <= (offset == '0) ? AW'(MSG_LEN - 1) : offset - AW'(1);
        end else begin
          offset <= (offset == AW'(MSG_LEN - 1)) ? '0 : offset + AW'(1);
        end
      end
    end else if (swap) begin
      swap_pending <= 1'b1;
    end
  end

  // Scan index selects one digit in each bank: anodes k and k+HALF.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_idx <= '0;
    end else if (scan_tick) begin
      scan_idx <= (scan_idx == KW'(HALF - 1)) ? '0 : scan_idx + KW'(1);
    end
  end

  // Anode a sits at position N_DIGITS-1-a from the left, and position p
  // shows active[(offset+p) mod MSG_LEN].
  always_comb begin
    idx_right = AW'((int'(offset) + (N_DIGITS - 1) - int'(scan_idx)) % MSG_LEN);
    idx_left  = AW'((int'(offset) + (HALF - 1) - int'(scan_idx)) % MSG_LEN);
    an_low    = N_DIGITS'(1) << scan_idx;
  end

  // Registered output stage, refreshed only on scan ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      an    <= '0;
      duan  <= '0;
      duan1 <= '0;
    end else if (scan_tick) begin
      an    <= an_low | (an_low << HALF);
      duan  <= seg_font(32'(active[idx_right]));
      duan1 <= seg_font(32'(active[idx_left]));
    end
  end

endmodule
